// File: rtl/register_file.sv
// register_file -- 32 x WORDSIZE register file with two combinational read
// ports, one synchronous write port and a sticky overflow flag.
// x0 always reads as zero and silently absorbs writes.
// Optional feature: define REGFILE_BYPASS_EN to forward the in-flight
// write_data to a read port addressing the register being written.
module register_file #(
   parameter int WORDSIZE = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [4:0]          read_addr_a,
   input  logic [4:0]          read_addr_b,
   output logic [WORDSIZE-1:0] read_data_a,
   output logic [WORDSIZE-1:0] read_data_b,
   input  logic                write_enable,
   input  logic [4:0]          write_addr,
   input  logic [WORDSIZE-1:0] write_data,
   input  logic                write_overflow,
   output logic                overflow_flag
);

   // Register storage; entry 0 is only ever cleared, never written.
   logic [WORDSIZE-1:0] regs_reg [32];
   logic                overflow_reg;

   // A write is committed only for non-zero destinations.
   logic write_commit;
   assign write_commit = write_enable && (write_addr != 5'd0);

   // Storage update: reset clears everything and wins over a simultaneous write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (write_commit) begin
         regs_reg[write_addr] <= write_data;
      end
   end

   // Sticky overflow: set by any enabled write (x0 included), cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_reg <= 1'b0;
      end else if (write_enable && write_overflow) begin
         overflow_reg <= 1'b1;
      end
   end

   assign overflow_flag = overflow_reg;

   // Shared read-port logic: x0 forced to zero, optional write-through.
   function automatic logic [WORDSIZE-1:0] read_port(input logic [4:0] addr);
      logic [WORDSIZE-1:0] value;
      value = '0;
      if (addr != 5'd0) begin
`ifdef REGFILE_BYPASS_EN
         if (write_commit && (write_addr == addr)) begin
            value = write_data;
         end else begin
            value = regs_reg[addr];
         end
`else
         value = regs_reg[addr];
`endif
      end
      return value;
   endfunction

   // Combinational, zero-latency reads on both independent ports.
   always_comb begin
      read_data_a = '0;
      read_data_b = '0;
      read_data_a = read_port(read_addr_a);
      read_data_b = read_port(read_addr_b);
   end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file -- directed and randomized checks of register_file
// against a behavioural array model of the register file.
module tb_register_file;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic [4:0]   read_addr_a, read_addr_b, write_addr;
   logic [W-1:0] read_data_a, read_data_b, write_data;
   logic         write_enable, write_overflow, overflow_flag;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [W-1:0] model [32];
   logic         model_ovf;

   register_file #(.WORDSIZE(W)) dut (
      .clk(clk),
      .reset(reset),
      .read_addr_a(read_addr_a),
      .read_addr_b(read_addr_b),
      .read_data_a(read_data_a),
      .read_data_b(read_data_b),
      .write_enable(write_enable),
      .write_addr(write_addr),
      .write_data(write_data),
      .write_overflow(write_overflow),
      .overflow_flag(overflow_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected value on a read port in the current cycle.
   function automatic logic [W-1:0] exp_read(input logic [4:0] ra, input logic we,
                                             input logic [4:0] wa, input logic [W-1:0] wd);
      if (ra == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (we && wa == ra) return wd;
`endif
      return model[ra];
   endfunction

   // One clock cycle: drive inputs, check reads/flag mid-cycle, then commit the model.
   task automatic step(input bit do_chk, input logic rst, input logic we, input logic [4:0] wa,
                       input logic [W-1:0] wd, input logic wo,
                       input logic [4:0] ra, input logic [4:0] rb, input string tag);
      @(negedge clk);
      reset = rst; write_enable = we; write_addr = wa; write_data = wd;
      write_overflow = wo; read_addr_a = ra; read_addr_b = rb;
      #1;
      if (do_chk) begin
         chk({tag, "_a"}, read_data_a, exp_read(ra, we, wa, wd));
         chk({tag, "_b"}, read_data_b, exp_read(rb, we, wa, wd));
         chk({tag, "_ovf"}, {{(W-1){1'b0}}, overflow_flag}, {{(W-1){1'b0}}, model_ovf});
      end
      $display("cycle rst=%0b we=%0b wa=%0d wd=%h wo=%0b ra=%0d rb=%0d rda=%h rdb=%h ovf=%0b [%s]",
               rst, we, wa, wd, wo, ra, rb, read_data_a, read_data_b, overflow_flag, tag);
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) model[i] = '0;
         model_ovf = 1'b0;
      end else if (we) begin
         if (wa != 5'd0) model[wa] = wd;
         if (wo) model_ovf = 1'b1;
      end
   endtask

   // Read every register on both ports without writing.
   task automatic sweep(input string tag);
      for (int i = 0; i < 32; i++) begin
         step(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'(i), 5'(31 - i), tag);
      end
   endtask

   initial begin
      logic [W-1:0] rnd;
      for (int i = 0; i < 32; i++) model[i] = '0;
      model_ovf = 1'b0;
      reset = 1'b1; write_enable = 1'b0; write_addr = '0; write_data = '0;
      write_overflow = 1'b0; read_addr_a = '0; read_addr_b = '0;

      // reset, then reads of x5/x31 are zero and flag is clear
      step(1'b0, 1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, "init_rst");
      step(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd5, 5'd31, "post_rst");
      step(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd31, 5'd5, "post_rst_swap");

      // write x7, read back A=x7 B=x0
      step(1'b1, 1'b0, 1'b1, 5'd7, 64'h1234_5678_9ABC_DEF0, 1'b0, 5'd7, 5'd0, "wr_x7");
      step(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd7, 5'd0, "rd_x7");
      #1;
      chk("x7_literal", read_data_a, 64'h1234_5678_9ABC_DEF0);
      chk("x0_literal", read_data_b, 64'h0);

      // writes to x0 vanish; all other registers unchanged
      step(1'b1, 1'b0, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0, 5'd7, "wr_x0");
      sweep("sweep_after_x0");

      // same-cycle read of the register being written
      step(1'b1, 1'b0, 1'b1, 5'd3, 64'hAA, 1'b0, 5'd3, 5'd3, "wr_x3_same");
      step(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd3, 5'd3, "rd_x3_next");

      // write_overflow without write_enable is ignored
      step(1'b1, 1'b0, 1'b0, 5'd4, 64'h1, 1'b1, 5'd4, 5'd2, "ovf_no_we");
      step(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd4, 5'd2, "ovf_no_we_chk");

      // overflow sticks through idle cycles, reset clears flag and x2
      step(1'b1, 1'b0, 1'b1, 5'd2, 64'hDEAD_BEEF, 1'b1, 5'd2, 5'd0, "ovf_wr");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd2, 5'd7, "ovf_idle");
      step(1'b1, 1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd2, 5'd7, "ovf_rst");
      step(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd2, 5'd7, "ovf_after_rst");

      // overflow set by a write aimed at x0
      step(1'b1, 1'b0, 1'b1, 5'd0, 64'h77, 1'b1, 5'd0, 5'd1, "ovf_x0");
      step(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd1, "ovf_x0_chk");

      // reset wins over a simultaneous write; all reads zero afterwards
      step(1'b1, 1'b0, 1'b1, 5'd9, 64'h11, 1'b0, 5'd9, 5'd9, "pre_x9");
      step(1'b1, 1'b1, 1'b1, 5'd9, 64'h55, 1'b0, 5'd9, 5'd0, "rst_wr_x9");
      sweep("sweep_after_rst");

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         rnd = {$urandom, $urandom};
         step(1'b1, ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
              5'($urandom_range(0, 31)), rnd, ($urandom_range(0, 29) == 0),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand");
      end
      sweep("sweep_final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
- REQ-001 SHALL have parameter WORDSIZE, default 64: width of every register and data port.
- REQ-002 SHALL have clk, input, 1: single clock; all state updates occur on its rising edge.
- REQ-003 SHALL have reset, input, 1: synchronous, active-high reset, sampled on rising clk.
- REQ-004 SHALL have read_addr_a, input, 5: register index for port A.
- REQ-005 SHALL have read_addr_b, input, 5: register index for port B.
- REQ-006 SHALL have read_data_a, output, WORDSIZE: contents of register read_addr_a; feeds ALU input_a.
- REQ-007 SHALL have read_data_b, output, WORDSIZE: contents of register read_addr_b; feeds ALU input_b.
- REQ-008 SHALL have write_enable, input, 1: commit write_data to write_addr this cycle.
- REQ-009 SHALL have write_addr, input, 5: destination register index.
- REQ-010 SHALL have write_data, input, WORDSIZE: value to store; sourced from ALU result.
- REQ-011 SHALL have write_overflow, input, 1: ALU overflow accompanying write_data.
- REQ-012 SHALL have overflow_flag, output, 1: sticky overflow status.

Function
- REQ-013 SHALL hold 32 registers x0..x31 of WORDSIZE bits.
- REQ-014 SHALL provide combinational reads: read_data_a/b reflect the addressed register in the same cycle, with zero latency.
- REQ-015 SHALL return 0 for every read of x0, regardless of prior writes.
- REQ-016 SHALL update register write_addr with write_data on the rising clk when write_enable=1 and write_addr!=0.
- REQ-017 SHALL discard writes to x0 without side effects on any register.
- REQ-018 SHALL allow one write per cycle; the read ports are independent, and both may address the same register.
- REQ-019 SHALL set overflow_flag on the rising clk when write_enable=1 and write_overflow=1, including when write_addr=0.
- REQ-020 SHALL keep overflow_flag set until reset; it has no other clear path.
- REQ-021 SHALL ignore write_overflow when write_enable=0.
- REQ-022 SHALL, when write_enable=1 and a read address equals write_addr in the same cycle, return the old register value on that read port in that cycle (without REGFILE_BYPASS_EN) and the new value from the next cycle.

Reset
- REQ-023 SHALL, when reset=1 at a rising clk, clear all 32 registers to 0 and clear overflow_flag to 0.
- REQ-024 SHALL give reset priority over a simultaneous write; that write is lost.
- REQ-025 SHALL drive read_data_a/b to 0 for every address in the cycle following reset.

Configuration
- REQ-026 SHALL compile, when REGFILE_BYPASS_EN is defined, a write-through path: if write_enable=1, write_addr!=0 and a read address equals write_addr, that read port returns write_data in the same cycle.
- REQ-027 SHALL, when REGFILE_BYPASS_EN is defined, return 0 on a read of x0 even while x0 is being written.
- REQ-028 SHALL, when REGFILE_BYPASS_EN is undefined, behave as in REQ-022 with no bypass logic present.

Verification
- REQ-029 SHALL be tested with reset, then read x5/x31 -> both ports return 0 and overflow_flag=0.
- REQ-030 SHALL be tested by writing x7=0x1234_5678_9ABC_DEF0, then reading A=x7, B=x0 next cycle -> A=0x123456789ABCDEF0, B=0.
- REQ-031 SHALL be tested by writing x0=0xFFFF_FFFF_FFFF_FFFF, then reading x0 -> 0, with all other registers unchanged.
- REQ-032 SHALL be tested by writing x3=0xAA while reading x3 in the same cycle -> old value 0 without REGFILE_BYPASS_EN, 0xAA with it, and 0xAA next cycle in both builds.
- REQ-033 SHALL be tested with write_enable=1, write_overflow=1, write_addr=2, then three idle cycles -> overflow_flag=1 throughout; then reset -> overflow_flag=0 and x2=0.
- REQ-034 SHALL be tested with reset=1 and write_enable=1 to x9=0x55 in the same cycle -> x9 reads 0 afterwards.
